// File: rtl/mac_accumulator.sv
// rtl/mac_accumulator.sv - multiply-accumulate stage summing N_TERMS products per result
// Accepts products over a valid/ready handshake and holds each completed sum until accepted.
module mac_accumulator #(
  parameter int N_TERMS  = 4,
  parameter int ACC_W    = 12,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             p_valid,
  input  logic [7:0]       p_in,
  output logic             p_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic             ovf,
  output logic             busy
);

  localparam int CNT_W = $clog2(N_TERMS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t           state, state_next;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf_q;
  logic             xfer;
  logic [ACC_W:0]   sum;

  assign xfer = p_valid && (state == ACCUM);
  // One extra bit so the carry out of the accumulator is visible as overflow.
  assign sum  = {1'b0, acc} + {{(ACC_W - 7){1'b0}}, p_in};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ACCUM;
      ACCUM:   if (xfer && cnt == LAST_CNT) state_next = HOLD;
      HOLD:    if (acc_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      cnt   <= '0;
      ovf_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc   <= '0;
            cnt   <= '0;
            ovf_q <= 1'b0;
          end
        end
        ACCUM: begin
          if (xfer) begin
            cnt <= cnt + 1'b1;
            if (sum[ACC_W]) begin
              ovf_q <= 1'b1;
              acc   <= SATURATE ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
            end else begin
              acc <= sum[ACC_W-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Handshake outputs decode from state alone, never from p_valid or acc_ready.
  assign p_ready   = (state == ACCUM);
  assign acc_valid = (state == HOLD);
  assign busy      = (state != IDLE);
  assign acc_out   = acc;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// tb/tb_mac_accumulator.sv - randomized self-checking bench for mac_accumulator
// Three instances (12-bit saturating, 9-bit saturating, 9-bit wrapping) share one stimulus stream.
module tb_mac_accumulator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic p_valid = 1'b0;
  logic [7:0] p_in = 8'd0;
  logic acc_ready = 1'b0;

  logic        pr_a, av_a, ov_a, bz_a;
  logic [11:0] ao_a;
  logic        pr_b, av_b, ov_b, bz_b;
  logic [8:0]  ao_b;
  logic        pr_c, av_c, ov_c, bz_c;
  logic [8:0]  ao_c;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mac_accumulator #(.N_TERMS(4), .ACC_W(12), .SATURATE(1'b1)) dut_a (
    .clk(clk), .rst(rst), .start(start), .p_valid(p_valid), .p_in(p_in),
    .p_ready(pr_a), .acc_out(ao_a), .acc_valid(av_a), .acc_ready(acc_ready),
    .ovf(ov_a), .busy(bz_a));

  mac_accumulator #(.N_TERMS(4), .ACC_W(9), .SATURATE(1'b1)) dut_b (
    .clk(clk), .rst(rst), .start(start), .p_valid(p_valid), .p_in(p_in),
    .p_ready(pr_b), .acc_out(ao_b), .acc_valid(av_b), .acc_ready(acc_ready),
    .ovf(ov_b), .busy(bz_b));

  mac_accumulator #(.N_TERMS(4), .ACC_W(9), .SATURATE(1'b0)) dut_c (
    .clk(clk), .rst(rst), .start(start), .p_valid(p_valid), .p_in(p_in),
    .p_ready(pr_c), .acc_out(ao_c), .acc_valid(av_c), .acc_ready(acc_ready),
    .ovf(ov_c), .busy(bz_c));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  // Reference: result depends only on the running total of products.
  function automatic int exp_acc(input int total, input int w, input bit sat);
    int lim = 1 << w;
    if (sat) return (total >= lim) ? lim - 1 : total;
    return total % lim;
  endfunction

  function automatic int exp_ovf(input int total, input int w);
    return (total >= (1 << w)) ? 1 : 0;
  endfunction

  task automatic check_accs(input string tag, input int total);
    check({tag, " acc_a"}, 32'(ao_a), 32'(exp_acc(total, 12, 1'b1)));
    check({tag, " acc_b"}, 32'(ao_b), 32'(exp_acc(total, 9, 1'b1)));
    check({tag, " acc_c"}, 32'(ao_c), 32'(exp_acc(total, 9, 1'b0)));
    check({tag, " ovf_a"}, 32'(ov_a), 32'(exp_ovf(total, 12)));
    check({tag, " ovf_b"}, 32'(ov_b), 32'(exp_ovf(total, 9)));
    check({tag, " ovf_c"}, 32'(ov_c), 32'(exp_ovf(total, 9)));
  endtask

  task automatic check_ctrl(input string tag, input bit pr, input bit av, input bit bz);
    check({tag, " p_ready"}, 32'(pr_a), 32'(pr));
    check({tag, " acc_valid"}, 32'(av_a), 32'(av));
    check({tag, " busy"}, 32'(bz_a), 32'(bz));
    check({tag, " ctrl_bc"}, 32'({pr_b, av_b, bz_b, pr_c, av_c, bz_c}), 32'({pr, av, bz, pr, av, bz}));
  endtask

  // gaps[i] = idle cycles before transfer i; poke drives start in gaps and in HOLD.
  task automatic run_result(input int vals[$], input int gaps[$], input bit poke, input int hold_cycles);
    int total = 0;
    start = 1'b1;
    tick;
    start = 1'b0;
    check_ctrl("accum_entry", 1'b1, 1'b0, 1'b1);
    check_accs("cleared", 0);
    foreach (vals[i]) begin
      repeat (gaps[i]) begin
        p_valid = 1'b0;
        p_in = 8'($urandom);
        start = poke;
        tick;
        start = 1'b0;
        check_ctrl("gap", 1'b1, 1'b0, 1'b1);
      end
      p_valid = 1'b1;
      p_in = 8'(vals[i]);
      tick;
      p_valid = 1'b0;
      total += vals[i];
      check_accs("partial", total);
      if (i < vals.size() - 1) check_ctrl("mid", 1'b1, 1'b0, 1'b1);
      else                     check_ctrl("latency", 1'b0, 1'b1, 1'b1);
    end
    acc_ready = 1'b0;
    repeat (hold_cycles) begin
      start = poke;
      tick;
      start = 1'b0;
      check_ctrl("hold", 1'b0, 1'b1, 1'b1);
      check_accs("hold", total);
    end
    acc_ready = 1'b1;
    start = poke;
    tick;
    acc_ready = 1'b0;
    start = 1'b0;
    check_ctrl("release", 1'b0, 1'b0, 1'b0);
    check_accs("idle_keep", total);
  endtask

  initial begin
    int vals[$];
    int gaps[$];

    repeat (2) tick;
    check_ctrl("reset", 1'b0, 1'b0, 1'b0);
    check_accs("reset", 0);
    rst = 1'b0;
    tick;
    check_ctrl("idle", 1'b0, 1'b0, 1'b0);

    vals = '{225, 225, 225, 225}; gaps = '{0, 0, 0, 0};
    run_result(vals, gaps, 1'b0, 0);

    vals = '{1, 2, 3, 4};
    run_result(vals, gaps, 1'b0, 5);

    vals = '{16, 16, 16, 16}; gaps = '{0, 2, 1, 0};
    run_result(vals, gaps, 1'b1, 1);

    // Asynchronous abort two transfers into an accumulation.
    start = 1'b1; tick; start = 1'b0;
    repeat (2) begin
      p_valid = 1'b1; p_in = 8'd200; tick;
    end
    p_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_ctrl("async_rst", 1'b0, 1'b0, 1'b0);
    check_accs("async_rst", 0);
    tick;
    rst = 1'b0;
    tick;
    check_ctrl("post_rst", 1'b0, 1'b0, 1'b0);
    vals = '{1, 1, 1, 1}; gaps = '{0, 0, 0, 0};
    run_result(vals, gaps, 1'b0, 0);

    vals = '{255, 255, 255, 255};
    run_result(vals, gaps, 1'b0, 0);
    vals = '{1, 1, 1, 1};
    run_result(vals, gaps, 1'b0, 0);

    for (int r = 0; r < 25; r++) begin
      vals.delete(); gaps.delete();
      for (int k = 0; k < 4; k++) begin
        vals.push_back(($urandom_range(0, 3) == 0) ? 225 : int'($urandom_range(0, 255)));
        gaps.push_back(int'($urandom_range(0, 3)));
      end
      run_result(vals, gaps, 1'($urandom_range(0, 1)), int'($urandom_range(0, 4)));
      repeat ($urandom_range(0, 2)) tick;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
